// File: rtl/fws_pkg.sv
// Shared types and helpers for the frame write scheduler: FSM states,
// default frame geometry and the raster pixel-address function.
package fws_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fws_state_t;

   localparam int unsigned H_RES_DEFAULT = 640;
   localparam int unsigned V_RES_DEFAULT = 480;

   function automatic logic [31:0] pix_addr(input logic [9:0] x, input logic [9:0] y,
                                            input int unsigned h_res);
      return 32'(y) * h_res + 32'(x);
   endfunction

endpackage

// File: rtl/frame_write_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from an N-bit request vector; the
// pointer moves to one past the granted requester.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_next;
   logic          found;

   // Two passes: requesters at or above the pointer first, then the rest.
   always_comb begin
      grant    = '0;
      ptr_next = ptr;
      found    = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && req[i] && (i >= 32'(ptr))) begin
            grant[i] = 1'b1;
            found    = 1'b1;
            ptr_next = (i == N - 1) ? '0 : PW'(i + 1);
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && req[i] && (i < 32'(ptr))) begin
            grant[i] = 1'b1;
            found    = 1'b1;
            ptr_next = (i == N - 1) ? '0 : PW'(i + 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) ptr <= '0;
      else        ptr <= ptr_next;
   end

endmodule

// File: rtl/frame_write_sched.sv
// Frame write scheduler: dispatches raster pixels to iteration engines and
// writes their results to the framebuffer. Option: FWS_KEEP_DISPLAY_EN.
module frame_write_sched
   import fws_pkg::*;
#(
   parameter int unsigned N_ENG  = 4,
   parameter int unsigned WIDTH  = 7,
   parameter int unsigned H_RES  = H_RES_DEFAULT,
   parameter int unsigned V_RES  = V_RES_DEFAULT,
   parameter int unsigned ADDR_W = 19
) (
   input  logic                   CLK_100MHz,
   input  logic                   reset,
   input  logic                   start,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   read_enable,
   input  logic [N_ENG-1:0]       eng_idle,
   output logic [N_ENG-1:0]       eng_start,
   output logic [9:0]             eng_x,
   output logic [9:0]             eng_y,
   input  logic [N_ENG-1:0]       eng_valid,
   input  logic [N_ENG*WIDTH-1:0] eng_iter,
   output logic [N_ENG-1:0]       eng_ack,
   output logic                   wea,
   output logic [ADDR_W-1:0]      addr_w,
   output logic [WIDTH-1:0]       dina
);

   localparam int unsigned CNT_W  = $clog2(N_ENG + 1);
   localparam logic [9:0]  X_LAST = 10'(H_RES - 1);
   localparam logic [9:0]  Y_LAST = 10'(V_RES - 1);

   fws_state_t        state;
   logic [9:0]        x;
   logic [9:0]        y;
   logic [CNT_W-1:0]  outstanding;
   logic [N_ENG-1:0]  tag_held;
   logic [N_ENG-1:0]  ack_pending;
   logic [N_ENG-1:0]  dispatch_oh;
   logic [N_ENG-1:0]  write_req;
   logic [N_ENG-1:0]  grant;
   logic [ADDR_W-1:0] tag [N_ENG];
   logic [ADDR_W-1:0] tag_sel;
   logic [ADDR_W-1:0] cur_addr;
   logic [WIDTH-1:0]  iter_sel;
   logic              dispatch_go;
   logic              write_go;
   logic              last_pix;
   logic              disp_found;

   assign cur_addr    = ADDR_W'(pix_addr(x, y, H_RES));
   assign last_pix    = (x == X_LAST) && (y == Y_LAST);
   // Engines being re-dispatched this cycle may still show a stale valid.
   assign write_req   = eng_valid & tag_held & ~ack_pending & ~eng_start;
   assign write_go    = |grant;
   assign dispatch_go = (state == RUN) && (|dispatch_oh);

   always_comb begin
      dispatch_oh = '0;
      disp_found  = 1'b0;
      for (int unsigned i = 0; i < N_ENG; i++) begin
         if (!disp_found && eng_idle[i] && !tag_held[i]) begin
            dispatch_oh[i] = 1'b1;
            disp_found     = 1'b1;
         end
      end
   end

   always_comb begin
      tag_sel  = '0;
      iter_sel = '0;
      for (int unsigned i = 0; i < N_ENG; i++) begin
         if (grant[i]) begin
            tag_sel  = tag[i];
            iter_sel = eng_iter[i*WIDTH +: WIDTH];
         end
      end
   end

   rr_arbiter #(.N(N_ENG)) u_wr_arb (
      .clk   (CLK_100MHz),
      .reset (reset),
      .req   (write_req),
      .grant (grant)
   );

   always_ff @(posedge CLK_100MHz) begin
      if (!reset) begin
         state       <= IDLE;
         x           <= '0;
         y           <= '0;
         outstanding <= '0;
         tag_held    <= '0;
         ack_pending <= '0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         read_enable <= 1'b0;
         eng_start   <= '0;
         eng_x       <= '0;
         eng_y       <= '0;
         eng_ack     <= '0;
         wea         <= 1'b0;
         addr_w      <= '0;
         dina        <= '0;
         for (int unsigned i = 0; i < N_ENG; i++) tag[i] <= '0;
      end else begin
         eng_start   <= '0;
         frame_done  <= 1'b0;
         eng_ack     <= grant;
         ack_pending <= grant;
         wea         <= write_go;
         tag_held    <= (tag_held & ~grant) | (dispatch_go ? dispatch_oh : '0);
         outstanding <= outstanding + CNT_W'(dispatch_go) - CNT_W'(write_go);
         if (write_go) begin
            addr_w <= tag_sel;
            dina   <= iter_sel;
         end
         if (dispatch_go) begin
            eng_start <= dispatch_oh;
            eng_x     <= x;
            eng_y     <= y;
            for (int unsigned i = 0; i < N_ENG; i++) begin
               if (dispatch_oh[i]) tag[i] <= cur_addr;
            end
            if (x == X_LAST) begin
               x <= '0;
               y <= (y == Y_LAST) ? '0 : y + 10'd1;
            end else begin
               x <= x + 10'd1;
            end
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  x     <= '0;
                  y     <= '0;
`ifdef FWS_KEEP_DISPLAY_EN
`else
                  read_enable <= 1'b0;
`endif
               end
            end
            RUN: begin
               if (dispatch_go && last_pix) state <= DRAIN;
            end
            DRAIN: begin
               if (outstanding == '0) state <= DONE;
            end
            DONE: begin
               frame_done  <= 1'b1;
               read_enable <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_write_sched.sv
// Self-checking bench for frame_write_sched on an 8x4 frame with four
// behavioural engines and an address/data scoreboard.
module tb_frame_write_sched;

   localparam int NE = 4;
   localparam int W  = 7;
   localparam int H  = 8;
   localparam int V  = 4;
   localparam int AW = 19;
   localparam int NP = H * V;

   logic            CLK_100MHz = 1'b0;
   logic            reset = 1'b0;
   logic            start = 1'b0;
   logic            busy, frame_done, read_enable;
   logic [NE-1:0]   eng_idle, eng_start, eng_valid, eng_ack;
   logic [9:0]      eng_x, eng_y;
   logic [NE*W-1:0] eng_iter;
   logic            wea;
   logic [AW-1:0]   addr_w;
   logic [W-1:0]    dina;

   always #5 CLK_100MHz = ~CLK_100MHz;

   frame_write_sched #(.N_ENG(NE), .WIDTH(W), .H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
      .CLK_100MHz (CLK_100MHz),
      .reset      (reset),
      .start      (start),
      .busy       (busy),
      .frame_done (frame_done),
      .read_enable(read_enable),
      .eng_idle   (eng_idle),
      .eng_start  (eng_start),
      .eng_x      (eng_x),
      .eng_y      (eng_y),
      .eng_valid  (eng_valid),
      .eng_iter   (eng_iter),
      .eng_ack    (eng_ack),
      .wea        (wea),
      .addr_w     (addr_w),
      .dina       (dina)
   );

   // Behavioural engines: latency from lat_cfg (0 = random), results held until acked.
   logic [NE-1:0] eng_en = '0;
   int unsigned   lat_cfg [NE];
   logic          gate = 1'b1;
   logic          bfm_clr = 1'b1;
   logic [NE-1:0] bfm_busy, bfm_valid;
   int unsigned   bfm_cnt [NE];
   logic [W-1:0]  bfm_res [NE];

   always @(posedge CLK_100MHz) begin
      for (int i = 0; i < NE; i++) begin
         if (bfm_clr) begin
            bfm_busy[i]  <= 1'b0;
            bfm_valid[i] <= 1'b0;
            bfm_cnt[i]   <= 0;
            bfm_res[i]   <= '0;
         end else if (eng_start[i]) begin
            bfm_busy[i]  <= 1'b1;
            bfm_valid[i] <= 1'b0;
            bfm_cnt[i]   <= (lat_cfg[i] != 0) ? lat_cfg[i] : $urandom_range(1, 12);
            bfm_res[i]   <= W'(eng_x + eng_y);
         end else if (bfm_busy[i]) begin
            if (bfm_cnt[i] <= 1) begin
               if (gate) begin
                  bfm_busy[i]  <= 1'b0;
                  bfm_valid[i] <= 1'b1;
               end
            end else begin
               bfm_cnt[i] <= bfm_cnt[i] - 1;
            end
         end else if (eng_ack[i]) begin
            bfm_valid[i] <= 1'b0;
         end
      end
   end

   assign eng_idle  = eng_en & ~bfm_busy;
   assign eng_valid = bfm_valid;
   always_comb begin
      eng_iter = '0;
      for (int i = 0; i < NE; i++) eng_iter[i*W +: W] = bfm_res[i];
   end

   // Scoreboard: expected data and dispatch order derived from raster arithmetic.
   int tests = 0, fails = 0;
   int cyc = 0;
   int wr_count, dup_cnt, bad_data, bad_tag, bad_ack, bad_order, bad_disp, range_cnt;
   int fd_count, disp_count, exp_pix;
   int seen [NP];
   int disp_tag [NE];
   bit disp_pend [NE];
   int ack_log [$];
   int wr_cyc [$];
   int disp_log [$];

   always @(negedge CLK_100MHz) begin
      int a, p;
      cyc++;
      if (wea) begin
         a = int'(addr_w);
         wr_count++;
         wr_cyc.push_back(cyc);
         if (a >= NP) range_cnt++;
         else begin
            if (seen[a] != 0) dup_cnt++;
            seen[a]++;
            if (dina !== W'(a % H + a / H)) bad_data++;
         end
         if ($countones(eng_ack) != 1) bad_ack++;
      end else if (eng_ack != '0) bad_ack++;
      for (int i = 0; i < NE; i++) begin
         if (eng_ack[i]) begin
            ack_log.push_back(i);
            if (!disp_pend[i]) bad_ack++;
            else if (int'(addr_w) != disp_tag[i]) bad_tag++;
            disp_pend[i] = 1'b0;
         end
      end
      if (eng_start != '0) begin
         p = int'(eng_y) * H + int'(eng_x);
         disp_log.push_back(p);
         disp_count++;
         if ($countones(eng_start) != 1) bad_disp++;
         if (p != exp_pix) bad_order++;
         exp_pix = (exp_pix + 1) % NP;
         for (int i = 0; i < NE; i++) begin
            if (eng_start[i]) begin
               if (disp_pend[i]) bad_disp++;
               disp_tag[i]  = p;
               disp_pend[i] = 1'b1;
            end
         end
      end
      if (frame_done) fd_count++;
   end

   task automatic clear_sb();
      wr_count = 0; dup_cnt = 0; bad_data = 0; bad_tag = 0; bad_ack = 0;
      bad_order = 0; bad_disp = 0; range_cnt = 0; fd_count = 0; disp_count = 0;
      exp_pix = 0;
      for (int i = 0; i < NP; i++) seen[i] = 0;
      for (int i = 0; i < NE; i++) begin disp_tag[i] = 0; disp_pend[i] = 1'b0; end
      ack_log.delete(); wr_cyc.delete(); disp_log.delete();
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK_100MHz);
      #1;
   endtask

   task automatic pulse_start();
      @(posedge CLK_100MHz); #1 start = 1'b1;
      @(posedge CLK_100MHz); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge CLK_100MHz);
         if (frame_done) ok = 1'b1;
      end
      @(posedge CLK_100MHz); #1;
   endtask

   task automatic wait_disp(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge CLK_100MHz);
         if (disp_count >= n) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; bfm_clr = 1'b1; eng_en = '0;
      tick(3);
      tests++; if ({busy, frame_done, read_enable, wea} !== 4'b0) begin fails++;
         $display("FAIL reset_flags: got %b, want 0000", {busy, frame_done, read_enable, wea}); end
      tests++; if (eng_start !== '0 || eng_ack !== '0) begin fails++;
         $display("FAIL reset_strobes: start=%b ack=%b, want 0", eng_start, eng_ack); end
      tests++; if (addr_w !== '0 || dina !== '0) begin fails++;
         $display("FAIL reset_write: addr=%0d dina=%0d, want 0", addr_w, dina); end
      tests++; if (eng_x !== '0 || eng_y !== '0) begin fails++;
         $display("FAIL reset_xy: x=%0d y=%0d, want 0", eng_x, eng_y); end
      bfm_clr = 1'b0; reset = 1'b1;
      tick(1);
   endtask

   task automatic test_single_engine();
      bit ok;
      clear_sb();
      eng_en = 4'b0001; lat_cfg[0] = 3; gate = 1'b1;
      pulse_start();
      tests++; if (busy !== 1'b1 || read_enable !== 1'b0) begin fails++;
         $display("FAIL single_start: busy=%b read_en=%b, want 1 0", busy, read_enable); end
      wait_done(2000, ok);
      tests++; if (!ok) begin fails++; $display("FAIL single_timeout: frame_done not seen, want pulse"); end
      tick(5);
      tests++; if (wr_count != NP || dup_cnt != 0 || range_cnt != 0) begin fails++;
         $display("FAIL single_writes: count=%0d dup=%0d range=%0d, want %0d 0 0", wr_count, dup_cnt, range_cnt, NP); end
      tests++; if (bad_data != 0) begin fails++; $display("FAIL single_data: bad=%0d, want 0", bad_data); end
      tests++; if (bad_order != 0 || disp_count != NP) begin fails++;
         $display("FAIL single_order: bad=%0d disp=%0d, want 0 %0d", bad_order, disp_count, NP); end
      tests++; if (fd_count != 1) begin fails++; $display("FAIL single_done: pulses=%0d, want 1", fd_count); end
      tests++; if (read_enable !== 1'b1 || busy !== 1'b0) begin fails++;
         $display("FAIL single_after: read_en=%b busy=%b, want 1 0", read_enable, busy); end
   endtask

   task automatic test_display_enable();
      bit ok;
      logic exp_re;
`ifdef FWS_KEEP_DISPLAY_EN
      exp_re = 1'b1;
`else
      exp_re = 1'b0;
`endif
      clear_sb();
      eng_en = 4'b1111; for (int i = 0; i < NE; i++) lat_cfg[i] = 0;
      pulse_start();
      tests++; if (read_enable !== exp_re) begin fails++;
         $display("FAIL display_restart: read_en=%b, want %b", read_enable, exp_re); end
      wait_done(2000, ok);
      tests++; if (!ok || read_enable !== 1'b1) begin fails++;
         $display("FAIL display_done: done=%0d read_en=%b, want 1 1", ok, read_enable); end
      tests++; if (wr_count != NP || dup_cnt != 0 || bad_data != 0 || bad_tag != 0) begin fails++;
         $display("FAIL display_frame: count=%0d dup=%0d data=%0d tag=%0d", wr_count, dup_cnt, bad_data, bad_tag); end
   endtask

   task automatic test_all_valid();
      bit ok;
      reset = 1'b0; bfm_clr = 1'b1;
      tick(2);
      reset = 1'b1; bfm_clr = 1'b0;
      clear_sb();
      eng_en = 4'b1111; for (int i = 0; i < NE; i++) lat_cfg[i] = 2; gate = 1'b0;
      pulse_start();
      wait_disp(4, 50, ok);
      tests++; if (!ok) begin fails++; $display("FAIL allv_dispatch: disp=%0d, want 4", disp_count); end
      tick(6);
      gate = 1'b1;
      for (int i = 0; i < 60 && ack_log.size() < 5; i++) tick(1);
      tests++; if (ack_log.size() < 5) begin fails++;
         $display("FAIL allv_acks: got %0d acks, want >=5", ack_log.size()); end
      else begin
         tests++; if (ack_log[0] != 0 || ack_log[1] != 1 || ack_log[2] != 2 || ack_log[3] != 3 || ack_log[4] != 0) begin
            fails++; $display("FAIL allv_order: got %0d %0d %0d %0d %0d, want 0 1 2 3 0",
                              ack_log[0], ack_log[1], ack_log[2], ack_log[3], ack_log[4]); end
         tests++; if (wr_cyc[3] - wr_cyc[0] != 3) begin fails++;
            $display("FAIL allv_burst: span=%0d cycles, want 3", wr_cyc[3] - wr_cyc[0]); end
      end
      wait_done(2000, ok);
      tests++; if (!ok || bad_ack != 0 || bad_disp != 0) begin fails++;
         $display("FAIL allv_ack: done=%0d bad_ack=%0d bad_disp=%0d, want 1 0 0", ok, bad_ack, bad_disp); end
      tests++; if (wr_count != NP || dup_cnt != 0 || bad_data != 0 || bad_tag != 0) begin fails++;
         $display("FAIL allv_frame: count=%0d dup=%0d data=%0d tag=%0d", wr_count, dup_cnt, bad_data, bad_tag); end
   endtask

   task automatic test_out_of_order();
      bit ok;
      int first0, first3;
      clear_sb();
      eng_en = 4'b1111; lat_cfg[0] = 12; lat_cfg[1] = 0; lat_cfg[2] = 0; lat_cfg[3] = 1;
      pulse_start();
      wait_done(3000, ok);
      first0 = -1; first3 = -1;
      foreach (ack_log[k]) begin
         if (ack_log[k] == 0 && first0 < 0) first0 = k;
         if (ack_log[k] == 3 && first3 < 0) first3 = k;
      end
      tests++; if (!ok || first3 < 0 || first0 < 0 || first3 > first0) begin fails++;
         $display("FAIL ooo_order: done=%0d first3=%0d first0=%0d, want 3 before 0", ok, first3, first0); end
      tests++; if (bad_tag != 0 || bad_ack != 0) begin fails++;
         $display("FAIL ooo_tag: bad_tag=%0d bad_ack=%0d, want 0 0", bad_tag, bad_ack); end
      tests++; if (wr_count != NP || dup_cnt != 0 || bad_data != 0 || fd_count != 1) begin fails++;
         $display("FAIL ooo_frame: count=%0d dup=%0d data=%0d done=%0d", wr_count, dup_cnt, bad_data, fd_count); end
   endtask

   task automatic test_start_during_run();
      bit ok;
      clear_sb();
      eng_en = 4'b1111; for (int i = 0; i < NE; i++) lat_cfg[i] = 0;
      pulse_start();
      tick(6);
      pulse_start();
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rerun_busy: busy=%b, want 1", busy); end
      wait_done(3000, ok);
      tick(40);
      tests++; if (!ok || fd_count != 1 || busy !== 1'b0) begin fails++;
         $display("FAIL rerun_done: done=%0d pulses=%0d busy=%b, want 1 1 0", ok, fd_count, busy); end
      tests++; if (disp_count != NP || bad_order != 0 || wr_count != NP || dup_cnt != 0 || bad_data != 0) begin
         fails++; $display("FAIL rerun_frame: disp=%0d order=%0d count=%0d dup=%0d data=%0d",
                           disp_count, bad_order, wr_count, dup_cnt, bad_data); end
   endtask

   task automatic test_reset_mid_run();
      bit ok;
      clear_sb();
      eng_en = 4'b1111; for (int i = 0; i < NE; i++) lat_cfg[i] = 0;
      pulse_start();
      wait_disp(14, 500, ok);
      tests++; if (!ok) begin fails++; $display("FAIL midrst_reach: disp=%0d, want 14", disp_count); end
      @(posedge CLK_100MHz); #1 reset = 1'b0;
      tick(1);
      tests++; if ({busy, frame_done, read_enable, wea} !== 4'b0 || eng_start !== '0 || eng_ack !== '0) begin
         fails++; $display("FAIL midrst_out: flags=%b start=%b ack=%b, want 0", {busy, frame_done, read_enable, wea}, eng_start, eng_ack); end
      tests++; if (addr_w !== '0 || dina !== '0 || eng_x !== '0 || eng_y !== '0) begin fails++;
         $display("FAIL midrst_data: addr=%0d dina=%0d x=%0d y=%0d, want 0", addr_w, dina, eng_x, eng_y); end
      tick(1);
      reset = 1'b1;
      clear_sb();
      tick(25);
      tests++; if (wr_count != 0 || disp_count != 0) begin fails++;
         $display("FAIL midrst_idle: writes=%0d disp=%0d, want 0 0", wr_count, disp_count); end
      pulse_start();
      wait_done(3000, ok);
      tests++; if (!ok || disp_log.size() == 0 || disp_log[0] != 0 || bad_order != 0) begin fails++;
         $display("FAIL midrst_restart: done=%0d first=%0d order=%0d, want 1 0 0", ok,
                  (disp_log.size() > 0) ? disp_log[0] : -1, bad_order); end
      tests++; if (wr_count != NP || dup_cnt != 0 || bad_data != 0 || bad_tag != 0 || fd_count != 1) begin
         fails++; $display("FAIL midrst_frame: count=%0d dup=%0d data=%0d tag=%0d done=%0d",
                           wr_count, dup_cnt, bad_data, bad_tag, fd_count); end
   endtask

   initial begin
      for (int i = 0; i < NE; i++) lat_cfg[i] = 0;
      clear_sb();
      test_reset();
      test_single_engine();
      test_display_enable();
      test_all_valid();
      test_out_of_order();
      test_start_during_run();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/frame_write_sched.md
Name: frame_write_sched

Overview:
- Scheduler that owns the framebuffer BRAM write port (wea/addr_w/dina) consumed by pixel_gen.
- Walks the frame in raster order and hands pixel coordinates to N_ENG Mandelbrot iteration engines.
- Collects their 7-bit iteration counts, arbitrates them round-robin onto the single write port, and raises read_enable once a full frame is written.

Parameters:
- N_ENG, 4, number of iteration engines served (1..8)
- WIDTH, 7, iteration-count width (equals BRAM data width)
- H_RES, 640, pixels per line
- V_RES, 480, lines per frame
- ADDR_W, 19, BRAM address width

Ports:
- CLK_100MHz  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse: begin rendering a frame
- busy  out  1  high from the cycle after an accepted start until DONE
- frame_done  out  1  one-cycle pulse when the last pixel has been written
- read_enable  out  1  to pixel_gen; frame valid for display
- eng_idle  in  N_ENG  engine i ready for a new pixel
- eng_start  out  N_ENG  one-hot dispatch strobe
- eng_x  out  10  dispatched pixel x, valid with eng_start
- eng_y  out  10  dispatched pixel y, valid with eng_start
- eng_valid  in  N_ENG  engine i holds a result
- eng_iter  in  N_ENG*WIDTH  packed results; engine i at [i*WIDTH +: WIDTH]
- eng_ack  out  N_ENG  one-hot; result of engine i consumed
- wea  out  1  BRAM write enable
- addr_w  out  ADDR_W  BRAM write address, y*H_RES+x
- dina  out  WIDTH  BRAM write data

Behaviour:
- Reset (reset==0 at a clock edge): every output is 0, x/y counters are 0, the outstanding count is 0, the round-robin pointer is 0, and the state is IDLE. Reset mid-frame abandons the frame; engine results still pending are ignored until they are re-dispatched.
- All outputs are registered.

FSM:
- IDLE: on start go to RUN.
- RUN: dispatch pixels; after pixel (H_RES-1, V_RES-1) is dispatched go to DRAIN.
- DRAIN: no dispatch; when outstanding==0 go to DONE.
- DONE: pulse frame_done for one cycle, set read_enable, return to IDLE.
- start outside IDLE is ignored.

Dispatch:
- At most one dispatch per cycle, to the lowest-index engine with eng_idle=1 and no tag held.
- eng_start, eng_x and eng_y are registered, so they appear the cycle after selection.
- The scheduler stores the tag addr=y*H_RES+x for that engine.
- x wraps from H_RES-1 to 0, incrementing y.

Write arbitration:
- Round-robin over eng_valid & ~ack_pending. The pointer advances to one past the granted engine.
- A grant selected in cycle t produces wea=1, addr_w=tag[i], dina=eng_iter[i] and eng_ack[i]=1 in cycle t+1, with ack_pending[i] set.
- The engine deasserts valid at t+2; ack_pending[i] clears at t+2.
- Sustained throughput: one write per cycle.

Outstanding count:
- +1 per dispatch, -1 per write; a dispatch and a write in the same cycle leave it unchanged.
- It never exceeds N_ENG.
- A tag is released on write, so the engine can be re-dispatched in the cycle after its ack.

read_enable:
- Cleared on an accepted start, so the display blanks during re-render.
- Set in DONE.

Optional Feature:
- Macro FWS_KEEP_DISPLAY_EN.
- When defined: once a frame has completed, read_enable stays high across subsequent starts. The display shows the frame as it is being overwritten.
- When undefined: behaviour as specified in Behaviour.

Decomposition:
- Package fws_pkg holds the state enum (IDLE, RUN, DRAIN, DONE), H_RES/V_RES defaults, and a pixel-address function y*H_RES+x.
- Sub-module rr_arbiter (N-bit request, one-hot grant, rotating pointer) is used for write arbitration.

Test Plan:
- Single-engine frame, H_RES=8, V_RES=4, engine returns iter=x+y after 3 cycles. Required:
  - exactly 32 writes to addresses 0..31, each with dina=x+y;
  - one frame_done pulse; read_enable=1 afterwards.
- 4 engines all valid in the same cycle. Required: grants in order 0,1,2,3, then 0 again; wea high 4 consecutive cycles; no double ack.
- Out-of-order completion, engine 3 finishes before engine 0. Required: addr_w for each write matches that engine's dispatched tag; frame content is correct.
- Start pulsed during RUN. Required: ignored; counters continue; exactly one frame_done.
- reset low mid-RUN at pixel 13. Required: next cycle all outputs 0, state IDLE; a fresh start redispatches from (0,0).
- With FWS_KEEP_DISPLAY_EN, second start after a completed frame. Required: read_enable stays 1. Without the macro: read_enable drops to 0 the cycle after start.
